// File: rtl/leaky_relu_derivative_child_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaky_relu_derivative_child_if                                       |
// | Forward-sign capture / backward-gradient bundle for one column.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface leaky_relu_derivative_child_if;
   logic        lrd_clear_in;
   logic        lrd_fwd_valid_in;
   logic [15:0] lrd_fwd_data_in;
   logic        lrd_grad_valid_in;
   logic [15:0] lrd_grad_in;
   logic [15:0] lrd_leak_factor_in;
   logic [15:0] lrd_grad_out;
   logic        lrd_valid_out;
   logic        lrd_full;
   logic        lrd_empty;
   logic        lrd_overflow;
   logic        lrd_underflow;

   modport master (
      output lrd_clear_in, lrd_fwd_valid_in, lrd_fwd_data_in,
             lrd_grad_valid_in, lrd_grad_in, lrd_leak_factor_in,
      input  lrd_grad_out, lrd_valid_out, lrd_full, lrd_empty,
             lrd_overflow, lrd_underflow
   );

   modport slave (
      input  lrd_clear_in, lrd_fwd_valid_in, lrd_fwd_data_in,
             lrd_grad_valid_in, lrd_grad_in, lrd_leak_factor_in,
      output lrd_grad_out, lrd_valid_out, lrd_full, lrd_empty,
             lrd_overflow, lrd_underflow
   );
endinterface
`default_nettype wire

// File: rtl/leaky_relu_derivative_child.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | leaky_relu_derivative_child                                          |
// | Records pre-activation signs, applies leaky ReLU derivative to grads.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

// Q8.8 multiply, round half up, saturate to signed 16 bits.
module fxp_mul (
   input  logic signed [15:0] a,
   input  logic signed [15:0] b,
   output logic signed [15:0] y
);
   logic signed [31:0] w_prod;
   logic signed [31:0] w_rnd;

   always_comb begin
      w_prod = 32'(a) * 32'(b);
      w_rnd  = (w_prod + 32'sd128) >>> 8;
      if (w_rnd > 32'sd32767)
         y = 16'sh7FFF;
      else if (w_rnd < -32'sd32768)
         y = 16'sh8000;
      else
         y = w_rnd[15:0];
   end
endmodule

module leaky_relu_derivative_child #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   leaky_relu_derivative_child_if.slave lrd
);
   localparam int               c_PTR_W  = $clog2(DEPTH);
   localparam logic [c_PTR_W:0] c_FULL   = (c_PTR_W + 1)'(DEPTH);
   localparam logic [c_PTR_W:0] c_CNT1   = (c_PTR_W + 1)'(1);
   localparam logic [c_PTR_W-1:0] c_PTR1 = c_PTR_W'(1);

   logic                 r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;
   logic [15:0]          r_grad_out;
   logic                 r_valid_out;
   logic                 r_full;
   logic                 r_empty;
   logic                 r_overflow;
   logic                 r_underflow;

   logic                 w_fwd_neg;
   logic                 w_is_full;
   logic                 w_pop;
   logic                 w_push;
   logic [c_PTR_W:0]     w_next_count;
   logic signed [15:0]   w_mul;
   logic [15:0]          w_grad_d;

   assign w_fwd_neg = ($signed(lrd.lrd_fwd_data_in) < 16'sd0);
   assign w_is_full = (r_count == c_FULL);
   assign w_pop     = lrd.lrd_grad_valid_in && (r_count != '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push    = lrd.lrd_fwd_valid_in && (!w_is_full || w_pop);

   always_comb begin
      w_next_count = r_count;
      if (w_push && !w_pop)
         w_next_count = r_count + c_CNT1;
      else if (w_pop && !w_push)
         w_next_count = r_count - c_CNT1;
   end

   fxp_mul u_fxp_mul (
      .a (lrd.lrd_grad_in),
      .b (lrd.lrd_leak_factor_in),
      .y (w_mul)
   );

   assign w_grad_d = r_mem[r_rd_ptr] ? w_mul : lrd.lrd_grad_in;

   // Sign storage needs no reset; pointers gate which bits are reachable.
   always_ff @(posedge clk) begin
      if (w_push && !lrd.lrd_clear_in)
         r_mem[r_wr_ptr] <= w_fwd_neg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_grad_out  <= '0;
         r_valid_out <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (lrd.lrd_clear_in) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_grad_out  <= '0;
         r_valid_out <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_PTR1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_PTR1;
         r_count     <= w_next_count;
         r_full      <= (w_next_count == c_FULL);
         r_empty     <= (w_next_count == '0);
         r_valid_out <= w_pop;
         r_grad_out  <= w_pop ? w_grad_d : 16'h0000;
         if (lrd.lrd_fwd_valid_in && w_is_full && !w_pop)
            r_overflow <= 1'b1;
         if (lrd.lrd_grad_valid_in && (r_count == '0))
            r_underflow <= 1'b1;
      end
   end

   assign lrd.lrd_grad_out  = r_grad_out;
   assign lrd.lrd_valid_out = r_valid_out;
   assign lrd.lrd_full      = r_full;
   assign lrd.lrd_empty     = r_empty;
   assign lrd.lrd_overflow  = r_overflow;
   assign lrd.lrd_underflow = r_underflow;
endmodule
`default_nettype wire

// File: doc/leaky_relu_derivative_child.md
# leaky_relu_derivative_child

Backward-path counterpart of the per-column leaky ReLU stage. During the forward pass it records, per element, whether the pre-activation was negative. During the backward pass it applies the leaky ReLU derivative to each incoming gradient in the same element order. It sits in the vector unit beside the forward leaky ReLU child, one instance per column. It feeds the gradient path toward the weight-update logic.

## Interface
Parameters:
- DEPTH, 16, number of recorded pre-activation signs; power of two, ≥2.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset; asynchronous, active-high.
- lrd_clear_in  input  1  synchronous flush of recorded signs and sticky flags.
- lrd_fwd_valid_in  input  1  forward pre-activation present this cycle.
- lrd_fwd_data_in  input  16  signed Q8.8 pre-activation H.
- lrd_grad_valid_in  input  1  backward gradient present this cycle.
- lrd_grad_in  input  16  signed Q8.8 upstream gradient.
- lrd_leak_factor_in  input  16  signed Q8.8 leak factor; sampled on the pop cycle.
- lrd_grad_out  output  16  signed Q8.8 gradient after derivative.
- lrd_valid_out  output  1  lrd_grad_out valid.
- lrd_full  output  1  DEPTH signs stored.
- lrd_empty  output  1  no signs stored.
- lrd_overflow  output  1  sticky: a push was dropped.
- lrd_underflow  output  1  sticky: a gradient arrived with nothing to pair.

## Operation
- Storage: DEPTH×1-bit circular FIFO.
  - Push stores neg = (lrd_fwd_data_in < 0). H = 0 stores 0, matching the forward child's pass-through for H ≥ 0.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - A count of log2(DEPTH)+1 bits drives full and empty.
- Push: occurs when lrd_fwd_valid_in=1 and the FIFO can accept the entry.
- Pop: occurs when lrd_grad_valid_in=1 and count>0, where count is the value before this cycle.
- Derivative:
  - If the popped neg=0: lrd_grad_out ← lrd_grad_in.
  - If neg=1: lrd_grad_out ← fxp_mul(lrd_grad_in, lrd_leak_factor_in), using the codebase's fxp_mul instance with the same Q8.8 rounding and saturation as the forward path.
- Order is strict FIFO: the k-th gradient pairs with the k-th recorded pre-activation since the last reset or clear.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, the push is accepted because the pop frees a slot in the same cycle. No overflow.
  - When empty, the pop is rejected: lrd_underflow sets, lrd_valid_out=0 next cycle. The push still completes, giving count=1. There is no same-cycle bypass.
- Push while full with no pop: entry dropped, lrd_overflow ← 1, contents unchanged.
- Pop while empty: no output, lrd_underflow ← 1.
- lrd_clear_in=1:
  - Pointers, count and both sticky flags go to 0; lrd_valid_out ← 0 and lrd_grad_out ← 0 next cycle.
  - Any push or pop in the same cycle is ignored. Clear has priority.
- Sticky flags clear only on rst or lrd_clear_in.

## Timing
- Reset values: lrd_grad_out=0, lrd_valid_out=0, lrd_full=0, lrd_empty=1, lrd_overflow=0, lrd_underflow=0. Pointers and count are 0.
- Reset mid-operation asynchronously discards all stored signs. Stored sign bits need no reset; stale bits are unreachable.
- Latency: a gradient accepted at edge N produces lrd_valid_out=1 with lrd_grad_out in the cycle after edge N. Latency is 1 cycle, one output per accepted gradient, with no backpressure.
- In any cycle without an accepted pop, lrd_valid_out=0 and lrd_grad_out=0 (registered).
- lrd_full and lrd_empty are registered and reflect count after the edge. lrd_full=1 iff count==DEPTH; lrd_empty=1 iff count==0.
- Sticky flags assert in the cycle after the offending edge.
- Throughput: one push and one pop per cycle.

## Test plan
- Sign capture and pass-through:
  - Stimulus: push H = 0x0100, 0xFF00, 0x0000, 0xFE80. Then feed gradients 0x0200 ×4 with leak 0x0019.
  - Required outputs: 0x0200, fxp_mul(0x0200,0x0019)=0x0032, 0x0200, 0x0032. Valid is high on 4 consecutive cycles, 1 cycle after each input. lrd_empty=1 at the end.
- Full and overflow (DEPTH=16):
  - Stimulus: push 17 negatives.
  - Required response: lrd_full=1 after the 16th push and lrd_overflow=1 after the 17th. Then 16 gradients 0x0100 with leak 0x0080 all return 0x0080.
- Simultaneous push and pop at full:
  - Stimulus: with 16 stored, push a positive H and pop together.
  - Required response: lrd_full stays 1, no overflow. The 17th gradient overall returns unmodified.
- Underflow and empty-simultaneous:
  - Stimulus: pop when empty.
  - Required response: lrd_valid_out=0 and lrd_underflow=1.
  - Stimulus: push a negative and pop in the same cycle while empty.
  - Required response: no output, count=1, lrd_empty=0.
- Clear and reset:
  - Stimulus: store 5 entries with both sticky flags set, then assert lrd_clear_in together with a push and a pop.
  - Required response: next cycle lrd_empty=1, flags 0, lrd_valid_out=0.
  - Stimulus: repeat the fill, then assert rst asynchronously mid-stream.
  - Required response: all outputs at their reset values immediately.
- Wrap-around:
  - Stimulus: run 40 interleaved push/pop pairs with random signs.
  - Required response: outputs match the in-order sign model through pointer wrap.
